// File: rtl/serial_sched.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sched
//  Description : Round-robin arbiter feeding an LSB-first serializer with a
//                prescaled bit strobe and first-bit frame marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sched #(
    parameter int p_width = 8,
    parameter int p_ports = 4,
    parameter int p_div   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [p_ports-1:0]         i_req,
    input  logic [p_ports*p_width-1:0] i_dat,
    output logic [p_ports-1:0]         o_ack,
    output logic                       o_val,
    output logic                       o_stp,
    output logic                       o_frm,
    output logic [$clog2(p_ports)-1:0] o_src,
    output logic                       o_bsy
);

    localparam int c_sw = $clog2(p_ports);
    localparam int c_cw = (p_div > 1) ? $clog2(p_div) : 1;
    localparam int c_bw = $clog2(p_width);

    localparam logic [c_sw-1:0] c_port_last = c_sw'(p_ports - 1);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(p_width - 1);
    // Strobe is registered, so it is armed one count before the last.
    localparam logic [c_cw-1:0] c_div_pre   = c_cw'((p_div > 1) ? (p_div - 2) : 0);
    localparam logic            c_div_one   = (p_div == 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_sw-1:0]    r_last;
    logic [c_sw-1:0]    r_src;
    logic [p_ports-1:0] r_ack;
    logic               r_stp;
    logic               r_frm;
    logic               r_bsy;
    logic [c_cw-1:0]    r_cnt;
    logic [c_bw-1:0]    r_bit;
    logic [p_width-1:0] r_sh;

    logic [p_width-1:0] w_dat [p_ports];
    logic               w_gnt_vld;
    logic [c_sw-1:0]    w_gnt_idx;
    logic [c_sw-1:0]    w_cand;
    logic [p_ports-1:0] w_gnt_oh;

    generate
        for (genvar k = 0; k < p_ports; k++) begin : g_port
            assign w_dat[k]    = i_dat[k*p_width +: p_width];
            assign w_gnt_oh[k] = w_gnt_vld && (w_gnt_idx == c_sw'(k));
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the port just after
    // the last grant is the one left standing.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = p_ports; i >= 1; i--) begin
            w_cand = c_sw'((int'(r_last) + i) % p_ports);
            if (i_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_last  <= c_port_last;
            r_src   <= '0;
            r_ack   <= '0;
            r_stp   <= 1'b0;
            r_frm   <= 1'b0;
            r_bsy   <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state <= ST_SHIFT;
                        r_last  <= w_gnt_idx;
                        r_src   <= w_gnt_idx;
                        r_ack   <= w_gnt_oh;
                        r_bsy   <= 1'b1;
                        r_sh    <= w_dat[w_gnt_idx];
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_stp   <= c_div_one;
                        r_frm   <= c_div_one;
                    end
                end
                ST_SHIFT: begin
                    if (r_stp) begin
                        r_sh  <= r_sh >> 1;
                        r_cnt <= '0;
                        r_frm <= 1'b0;
                        if (r_bit == c_bit_last) begin
                            r_state <= ST_IDLE;
                            r_bsy   <= 1'b0;
                            r_stp   <= 1'b0;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_stp <= c_div_one;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_stp <= (r_cnt == c_div_pre);
                        r_frm <= (r_cnt == c_div_pre) && (r_bit == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The shift register drains to zero, so bit 0 is also 0 once idle.
    assign o_val = r_sh[0];
    assign o_ack = r_ack;
    assign o_stp = r_stp;
    assign o_frm = r_frm;
    assign o_src = r_src;
    assign o_bsy = r_bsy;

endmodule
`default_nettype wire
